// File: rtl/add_order_parser.sv
// Add Order message collector: gathers one ITCH Add Order message from consecutive beats and emits its fields.
// Define ADD_ORDER_MPID_EN to also accept type 'F' messages and expose participant_id.
module add_order_parser #(
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 8,
    parameter int START_BEAT = 8,
    parameter int MSG_LANE   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              beat_valid,
    input  logic [CNT_W-1:0]  beat_cnt,
    input  logic              start_in,
    output logic              out_valid,
    output logic              msg_is_mpid,
    output logic [31:0]       time_stamp,
    output logic [63:0]       order_id,
    output logic [31:0]       order_book_id,
    output logic [7:0]        side,
    output logic [31:0]       order_book_pos,
    output logic [63:0]       quantity,
    output logic [31:0]       price,
    output logic [15:0]       order_attr,
    output logic [7:0]        lot_type,
    output logic              busy,
    output logic              err_abort
`ifdef ADD_ORDER_MPID_EN
    ,
    output logic [55:0]       participant_id
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int FIRST = BYTES - MSG_LANE;
    localparam int LEN_A = 37;
    localparam int LEN_F = 44;
`ifdef ADD_ORDER_MPID_EN
    localparam int MSG_MAX = LEN_F;
`else
    localparam int MSG_MAX = LEN_A;
`endif
    localparam int CW = $clog2(MSG_MAX + BYTES + 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [CNT_W-1:0]     last_reg, last_next;
    logic                 is_f_reg, is_f_next;
    // The type byte is tracked through is_f_reg, so the buffer starts at offset 1.
    logic [8*MSG_MAX-1:8] buf_reg, buf_next;

    logic [7:0]       lane_type;
    logic             start_cond, type_ok, lane_is_f;
    logic [CNT_W-1:0] expect_cnt;
    logic             consec;
    logic [CW-1:0]    append_cnt, cur_len;
    logic             append_done, start_done;
    logic             load_start, load_append, complete, abort;

    assign lane_type  = data_in[8*MSG_LANE +: 8];
    assign start_cond = start_in && beat_valid && (beat_cnt == CNT_W'(START_BEAT));
`ifdef ADD_ORDER_MPID_EN
    assign lane_is_f  = (lane_type == 8'h46);
    assign type_ok    = (lane_type == 8'h41) || lane_is_f;
`else
    assign lane_is_f  = 1'b0;
    assign type_ok    = (lane_type == 8'h41);
`endif

    assign expect_cnt  = last_reg + 1'b1;
    assign consec      = (beat_cnt == expect_cnt);
    assign append_cnt  = cnt_reg + CW'(BYTES);
    assign cur_len     = is_f_reg ? CW'(LEN_F) : CW'(LEN_A);
    assign append_done = (append_cnt >= cur_len);
    assign start_done  = lane_is_f ? (FIRST >= LEN_F) : (FIRST >= LEN_A);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        last_next   = last_reg;
        is_f_next   = is_f_reg;
        load_start  = 1'b0;
        load_append = 1'b0;
        complete    = 1'b0;
        abort       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_cond && type_ok)
                    load_start = 1'b1;
            end
            COLLECT: begin
                if (beat_valid) begin
                    if (consec && append_done) begin
                        load_append = 1'b1;
                        complete    = 1'b1;
                    end else if (start_cond) begin
                        abort      = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                        load_start = type_ok;
                    end else if (consec) begin
                        load_append = 1'b1;
                        cnt_next    = append_cnt;
                        last_next   = beat_cnt;
                    end else begin
                        abort      = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (load_start) begin
            is_f_next  = lane_is_f;
            last_next  = beat_cnt;
            state_next = COLLECT;
            cnt_next   = CW'(FIRST);
            complete   = start_done;
        end
        if (complete) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    // Each buffer byte takes either its start-beat lane or whichever lane lands on it when appending.
    for (genvar gi = 1; gi < MSG_MAX; gi++) begin : g_byte
        logic [7:0] start_byte, append_byte;
        if (gi < FIRST) begin : g_first
            assign start_byte = data_in[8*(gi+MSG_LANE) +: 8];
        end else begin : g_rest
            assign start_byte = 8'h00;
        end
        always_comb begin
            append_byte = buf_reg[8*gi +: 8];
            for (int k = 0; k < BYTES; k++) begin
                if (cnt_reg + CW'(k) == CW'(gi))
                    append_byte = data_in[8*k +: 8];
            end
        end
        assign buf_next[8*gi +: 8] = load_start  ? start_byte  :
                                     load_append ? append_byte : buf_reg[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        buf_reg <= buf_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= '0;
            is_f_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            is_f_reg  <= is_f_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            err_abort      <= 1'b0;
            time_stamp     <= '0;
            order_id       <= '0;
            order_book_id  <= '0;
            side           <= '0;
            order_book_pos <= '0;
            quantity       <= '0;
            price          <= '0;
            order_attr     <= '0;
            lot_type       <= '0;
        end else begin
            out_valid <= complete;
            err_abort <= abort;
            if (complete) begin
                time_stamp     <= buf_next[8*1  +: 32];
                order_id       <= buf_next[8*5  +: 64];
                order_book_id  <= buf_next[8*13 +: 32];
                side           <= buf_next[8*17 +: 8];
                order_book_pos <= buf_next[8*18 +: 32];
                quantity       <= buf_next[8*22 +: 64];
                price          <= buf_next[8*30 +: 32];
                order_attr     <= buf_next[8*34 +: 16];
                lot_type       <= buf_next[8*36 +: 8];
            end
        end
    end

`ifdef ADD_ORDER_MPID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_is_mpid    <= 1'b0;
            participant_id <= '0;
        end else if (complete) begin
            msg_is_mpid    <= is_f_next;
            participant_id <= buf_next[8*37 +: 56];
        end
    end
`else
    assign msg_is_mpid = 1'b0;
`endif

    assign busy = (state_reg == COLLECT);

endmodule

// File: tb/tb_add_order_parser.sv
// Bench for add_order_parser: table of hand-picked messages, multi-cycle corner sequences, then random beats vs a byte-queue model.
module tb_add_order_parser;

    localparam int DATA_W     = 64;
    localparam int CNT_W      = 4;
    localparam int START_BEAT = 8;
    localparam int MSG_LANE   = 2;
`ifdef ADD_ORDER_MPID_EN
    localparam bit MPID_ON = 1'b1;
`else
    localparam bit MPID_ON = 1'b0;
`endif

    logic              clk, rst;
    logic [DATA_W-1:0] data_in;
    logic              beat_valid;
    logic [CNT_W-1:0]  beat_cnt;
    logic              start_in;
    logic              out_valid, msg_is_mpid, busy, err_abort;
    logic [31:0]       time_stamp, order_book_id, order_book_pos, price;
    logic [63:0]       order_id, quantity;
    logic [7:0]        side, lot_type;
    logic [15:0]       order_attr;
`ifdef ADD_ORDER_MPID_EN
    logic [55:0]       participant_id;
`endif

    add_order_parser #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .START_BEAT(START_BEAT), .MSG_LANE(MSG_LANE)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .beat_valid(beat_valid),
        .beat_cnt(beat_cnt), .start_in(start_in), .out_valid(out_valid),
        .msg_is_mpid(msg_is_mpid), .time_stamp(time_stamp), .order_id(order_id),
        .order_book_id(order_book_id), .side(side), .order_book_pos(order_book_pos),
        .quantity(quantity), .price(price), .order_attr(order_attr),
        .lot_type(lot_type), .busy(busy), .err_abort(err_abort)
`ifdef ADD_ORDER_MPID_EN
        , .participant_id(participant_id)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ts;
        logic [63:0] oid;
        logic [31:0] obid;
        logic [7:0]  side;
        logic [31:0] pos;
        logic [63:0] qty;
        logic [31:0] price;
        logic [15:0] attr;
        logic [7:0]  lot;
        logic [55:0] pid;
    } rec_t;

    typedef struct {
        rec_t       f;
        logic [7:0] typ;
        bit         exp_valid;
        bit         exp_mpid;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t tbl [5];
    rec_t last_rec;
    bit   last_mpid;
    logic [7:0] msg [0:63];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic put(input int off, input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) msg[off+i] = v[8*i +: 8];
    endtask

    // Serialise a record into the message byte layout; unused tail bytes are random.
    task automatic build(input rec_t r, input logic [7:0] typ);
        for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
        msg[0] = typ;
        put(1, 4, 64'(r.ts));    put(5, 8, r.oid);        put(13, 4, 64'(r.obid));
        put(17, 1, 64'(r.side)); put(18, 4, 64'(r.pos));  put(22, 8, r.qty);
        put(30, 4, 64'(r.price)); put(34, 2, 64'(r.attr)); put(36, 1, 64'(r.lot));
        if (typ == 8'h46) put(37, 7, 64'(r.pid));
    endtask

    function automatic logic [63:0] beat_data(input int k);
        logic [63:0] d;
        int off;
        for (int l = 0; l < 8; l++) begin
            off = (k == 0) ? l - MSG_LANE : (8 - MSG_LANE) + 8*(k-1) + l;
            d[8*l +: 8] = (off >= 0) ? msg[off] : 8'($urandom);
        end
        return d;
    endfunction

    task automatic drive_beat(input logic [63:0] d, input logic [3:0] c, input bit st);
        data_in = d; beat_valid = 1'b1; beat_cnt = c; start_in = st;
        @(posedge clk); #1;
        beat_valid = 1'b0; start_in = 1'b0;
    endtask

    task automatic chk_fields(input rec_t r, input bit mpid);
        chk("time_stamp", 64'(time_stamp), 64'(r.ts));
        chk("order_id", order_id, r.oid);
        chk("order_book_id", 64'(order_book_id), 64'(r.obid));
        chk("side", 64'(side), 64'(r.side));
        chk("order_book_pos", 64'(order_book_pos), 64'(r.pos));
        chk("quantity", quantity, r.qty);
        chk("price", 64'(price), 64'(r.price));
        chk("order_attr", 64'(order_attr), 64'(r.attr));
        chk("lot_type", 64'(lot_type), 64'(r.lot));
        chk("msg_is_mpid", 64'(msg_is_mpid), 64'(mpid));
`ifdef ADD_ORDER_MPID_EN
        if (mpid) chk("participant_id", 64'(participant_id), 64'(r.pid));
`endif
    endtask

    task automatic run_vec(input vec_t v, input int stall_at, input int stall_n, input bit abort0);
        int nb;
        nb = (v.typ == 8'h46) ? 6 : 5;
        build(v.f, v.typ);
        for (int k = 0; k < nb; k++) begin
            drive_beat(beat_data(k), 4'(START_BEAT + k), k == 0);
            chk("out_valid", 64'(out_valid), 64'((k == nb-1) && v.exp_valid));
            chk("busy", 64'(busy), 64'(v.exp_valid && (k != nb-1)));
            if (k == 0) chk("err_abort_first", 64'(err_abort), 64'(abort0));
            if (k == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk); #1;
                    chk("stall_valid", 64'(out_valid), 64'(0));
                    chk("stall_busy", 64'(busy), 64'(v.exp_valid));
                end
            end
        end
        if (v.exp_valid) begin
            chk_fields(v.f, v.exp_mpid);
            last_rec = v.f; last_mpid = v.exp_mpid;
        end else begin
            chk_fields(last_rec, last_mpid);
        end
        $display("txn type=%h beats=%0d stall=%0d expect_valid=%0d price=%h", v.typ, nb, stall_n, v.exp_valid, price);
        @(posedge clk); #1;
        chk("pulse_end", 64'(out_valid), 64'(0));
        chk("abort_idle", 64'(err_abort), 64'(0));
    endtask

    // Behavioural reference: byte array of the message in progress plus expected field values.
    logic [7:0]  mb [0:63];
    bit          m_active, m_f;
    int          m_n, m_len;
    logic [3:0]  m_last;
    logic [63:0] e_ts, e_oid, e_obid, e_side, e_pos, e_qty, e_price, e_attr, e_lot, e_pid;
    bit          e_mpid;

    function automatic logic [63:0] le(input int off, input int n);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < n; i++) r = r | (64'(mb[off+i]) << (8*i));
        return r;
    endfunction

    task automatic m_complete();
        e_ts = le(1, 4); e_oid = le(5, 8); e_obid = le(13, 4); e_side = le(17, 1);
        e_pos = le(18, 4); e_qty = le(22, 8); e_price = le(30, 4); e_attr = le(34, 2);
        e_lot = le(36, 1); e_pid = le(37, 7); e_mpid = m_f;
        m_active = 1'b0;
    endtask

    task automatic model_step(input logic [63:0] d, input bit bv, input logic [3:0] c,
                              input bit st, output bit ov, output bit ab);
        bit startc, ok, consec;
        logic [7:0] typ;
        ov = 1'b0; ab = 1'b0;
        typ = d[8*MSG_LANE +: 8];
        startc = st && bv && (c == 4'(START_BEAT));
        ok = (typ == 8'h41) || (MPID_ON && typ == 8'h46);
        consec = (c == 4'(m_last + 4'd1));
        if (m_active && bv && consec && (m_n + 8 >= m_len)) begin
            for (int l = 0; l < 8; l++) if (m_n + l < 64) mb[m_n+l] = d[8*l +: 8];
            m_complete();
            ov = 1'b1;
        end else if (m_active && bv && !startc && consec) begin
            for (int l = 0; l < 8; l++) if (m_n + l < 64) mb[m_n+l] = d[8*l +: 8];
            m_n += 8;
            m_last = c;
        end else if (m_active && bv && !startc) begin
            ab = 1'b1;
            m_active = 1'b0;
        end else if (startc && (!m_active || bv)) begin
            if (m_active) ab = 1'b1;
            m_active = 1'b0;
            if (ok) begin
                for (int l = MSG_LANE; l < 8; l++) mb[l-MSG_LANE] = d[8*l +: 8];
                m_n = 8 - MSG_LANE;
                m_f = (typ == 8'h46);
                m_len = m_f ? 44 : 37;
                m_last = c;
                m_active = 1'b1;
            end
        end
    endtask

    initial begin
        rec_t r;
        logic [3:0] gen_cnt;
        logic [63:0] d;
        bit bv, st, ov, ab;

        tbl[0].f = '{ts: 32'h11223344, oid: 64'h0102030405060708, obid: 32'hAABBCCDD, side: 8'h42,
                     pos: 32'h00000005, qty: 64'h64, price: 32'h000186A0, attr: 16'h1234, lot: 8'h01, pid: 56'h0};
        tbl[0].typ = 8'h41; tbl[0].exp_valid = 1'b1; tbl[0].exp_mpid = 1'b0;
        tbl[1].f = '{ts: 32'hDEADBEEF, oid: 64'hFEDCBA9876543210, obid: 32'h00000001, side: 8'h53,
                     pos: 32'hFFFFFFFF, qty: 64'h8000000000000001, price: 32'h7FFFFFFF, attr: 16'hA5A5, lot: 8'hFF, pid: 56'h0};
        tbl[1].typ = 8'h41; tbl[1].exp_valid = 1'b1; tbl[1].exp_mpid = 1'b0;
        tbl[2].f = '{ts: 32'h0BADF00D, oid: 64'h1111111111111111, obid: 32'h22222222, side: 8'h33,
                     pos: 32'h44444444, qty: 64'h5555555555555555, price: 32'h66666666, attr: 16'h7777, lot: 8'h88, pid: 56'h0};
        tbl[2].typ = 8'h55; tbl[2].exp_valid = 1'b0; tbl[2].exp_mpid = 1'b0;
        tbl[3].f = '{ts: 32'hCAFEF00D, oid: 64'h0000000000ABCDEF, obid: 32'h12345678, side: 8'h42,
                     pos: 32'h00000010, qty: 64'h00000000000003E8, price: 32'h00012345, attr: 16'h0F0F, lot: 8'h02, pid: 56'h41424344454647};
        tbl[3].typ = 8'h46; tbl[3].exp_valid = MPID_ON; tbl[3].exp_mpid = MPID_ON;
        tbl[4].f = '{ts: 32'h00000000, oid: 64'h0000000000000001, obid: 32'h80000000, side: 8'h53,
                     pos: 32'h00000000, qty: 64'hFFFFFFFFFFFFFFFF, price: 32'h00000001, attr: 16'h0000, lot: 8'h00, pid: 56'h0};
        tbl[4].typ = 8'h41; tbl[4].exp_valid = 1'b1; tbl[4].exp_mpid = 1'b0;

        rst = 1'b1; data_in = '0; beat_valid = 1'b0; beat_cnt = '0; start_in = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err_abort", 64'(err_abort), 64'(0));
        chk("rst_price", 64'(price), 64'(0));
        chk("rst_order_id", order_id, 64'(0));
        chk("rst_quantity", quantity, 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        last_rec = '{ts: 0, oid: 0, obid: 0, side: 0, pos: 0, qty: 0, price: 0, attr: 0, lot: 0, pid: 0};
        last_mpid = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(tbl[i], -1, 0, 1'b0);

        // Stall of three idle cycles between beats 10 and 11.
        run_vec(tbl[1], 2, 3, 1'b0);

        // Gap: beat 9 followed by beat_cnt 11.
        build(tbl[0].f, 8'h41);
        drive_beat(beat_data(0), 4'd8, 1'b1);
        drive_beat(beat_data(1), 4'd9, 1'b0);
        drive_beat(beat_data(3), 4'd11, 1'b0);
        chk("gap_abort", 64'(err_abort), 64'(1));
        chk("gap_busy", 64'(busy), 64'(0));
        chk("gap_valid", 64'(out_valid), 64'(0));
        drive_beat(beat_data(4), 4'd12, 1'b0);
        chk("gap_abort_once", 64'(err_abort), 64'(0));
        chk("gap_no_valid", 64'(out_valid), 64'(0));
        chk_fields(last_rec, last_mpid);
        $display("txn gap at beat 11 err_abort pulse checked");

        // Restart: a fresh start at beat 8 while the previous message is half collected.
        build(tbl[0].f, 8'h41);
        drive_beat(beat_data(0), 4'd8, 1'b1);
        drive_beat(beat_data(1), 4'd9, 1'b0);
        drive_beat(beat_data(2), 4'd10, 1'b0);
        run_vec(tbl[4], -1, 0, 1'b1);

        // Asynchronous reset in the middle of beat 10.
        build(tbl[1].f, 8'h41);
        drive_beat(beat_data(0), 4'd8, 1'b1);
        drive_beat(beat_data(1), 4'd9, 1'b0);
        data_in = beat_data(2); beat_valid = 1'b1; beat_cnt = 4'd10;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_price", 64'(price), 64'(0));
        chk("arst_order_id", order_id, 64'(0));
        chk("arst_time_stamp", 64'(time_stamp), 64'(0));
        #1 rst = 1'b0;
        @(posedge clk); #1;
        beat_valid = 1'b0;
        drive_beat(beat_data(3), 4'd11, 1'b0);
        chk("arst_beat11", 64'(out_valid), 64'(0));
        drive_beat(beat_data(4), 4'd12, 1'b0);
        chk("arst_beat12", 64'(out_valid), 64'(0));
        $display("txn async reset mid-message checked");

        // Random beats against the reference model.
        m_active = 1'b0; m_n = 0; m_len = 37; m_last = '0; m_f = 1'b0;
        e_ts = 0; e_oid = 0; e_obid = 0; e_side = 0; e_pos = 0; e_qty = 0;
        e_price = 0; e_attr = 0; e_lot = 0; e_pid = 0; e_mpid = 1'b0;
        gen_cnt = 4'd5;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bv = ($urandom_range(0, 9) < 8);
            if (bv) gen_cnt = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(0, 15)) : gen_cnt + 4'd1;
            d = {$urandom, $urandom};
            st = (gen_cnt == 4'(START_BEAT)) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            if (gen_cnt == 4'(START_BEAT)) begin
                case ($urandom_range(0, 3))
                    0, 1:    d[8*MSG_LANE +: 8] = 8'h41;
                    2:       d[8*MSG_LANE +: 8] = 8'h46;
                    default: d[8*MSG_LANE +: 8] = 8'($urandom);
                endcase
            end
            model_step(d, bv, gen_cnt, st, ov, ab);
            data_in = d; beat_valid = bv; beat_cnt = gen_cnt; start_in = st;
            @(posedge clk); #1;
            chk("rnd_out_valid", 64'(out_valid), 64'(ov));
            chk("rnd_err_abort", 64'(err_abort), 64'(ab));
            chk("rnd_busy", 64'(busy), 64'(m_active));
            chk("rnd_price_hold", 64'(price), e_price);
            if (ov) begin
                chk("rnd_time_stamp", 64'(time_stamp), e_ts);
                chk("rnd_order_id", order_id, e_oid);
                chk("rnd_order_book_id", 64'(order_book_id), e_obid);
                chk("rnd_side", 64'(side), e_side);
                chk("rnd_order_book_pos", 64'(order_book_pos), e_pos);
                chk("rnd_quantity", quantity, e_qty);
                chk("rnd_order_attr", 64'(order_attr), e_attr);
                chk("rnd_lot_type", 64'(lot_type), e_lot);
                chk("rnd_msg_is_mpid", 64'(msg_is_mpid), 64'(e_mpid));
`ifdef ADD_ORDER_MPID_EN
                if (e_mpid) chk("rnd_participant_id", 64'(participant_id), e_pid);
`endif
                $display("txn rnd cyc=%0d complete mpid=%0d price=%h", cyc, e_mpid, e_price);
            end
            if (ab) $display("txn rnd cyc=%0d abort", cyc);
        end
        beat_valid = 1'b0; start_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
